// File: rtl/fetch_unit.sv
//==============================================================================
// Module   : fetch_unit
// Brief    : PC, one-outstanding imem handshake and IF/ID register.
//            Optional FETCH_PERF_CNT_EN adds saturating performance counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [XLEN-1:0] PCF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles,
    output logic [31:0]     perf_redirects
`endif
);

    localparam logic [XLEN-1:0] c_four = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t          r_state, w_stateNext;
    logic [XLEN-1:0] r_pcF, w_pcNext;
    logic [XLEN-1:0] r_oldAddr;
    logic [31:0]     r_holdInstr;
    logic [31:0]     r_instrD;
    logic [XLEN-1:0] r_pcD, r_pcPlus4D;
    logic            r_validD;
    logic            w_redirect, w_instrAvail, w_holdLoad;
    logic [31:0]     w_availInstr;
    logic [XLEN-1:0] w_target;

    assign w_redirect = (PCSrcE != 2'b00);
    // 2'b11 is reserved and behaves like a branch/jal target.
    assign w_target   = (PCSrcE == 2'b10) ? (ALUResultE & ~XLEN'(1)) : PCTargetE;

    always_comb begin
        w_stateNext  = r_state;
        w_pcNext     = r_pcF;
        w_instrAvail = 1'b0;
        w_holdLoad   = 1'b0;
        w_availInstr = imem_rdata;
        case (r_state)
            FETCH: begin
                if (w_redirect) begin
                    w_pcNext = w_target;
                    if (!imem_ack) w_stateNext = DROP;
                end else if (imem_ack) begin
                    if (StallF) begin
                        w_stateNext = HOLD;
                        w_holdLoad  = 1'b1;
                    end else begin
                        w_instrAvail = 1'b1;
                        w_pcNext     = r_pcF + c_four;
                    end
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_pcNext    = w_target;
                    w_stateNext = FETCH;
                end else if (!StallF) begin
                    w_instrAvail = 1'b1;
                    w_availInstr = r_holdInstr;
                    w_pcNext     = r_pcF + c_four;
                    w_stateNext  = FETCH;
                end
            end
            DROP: begin
                // PCF already carries the latched target; a new redirect overwrites it.
                if (w_redirect) w_pcNext = w_target;
                if (imem_ack) w_stateNext = FETCH;
            end
            default: w_stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FETCH;
            r_pcF       <= RESET_PC;
            r_oldAddr   <= RESET_PC;
            r_holdInstr <= NOP_INSTR;
        end else begin
            r_state <= w_stateNext;
            r_pcF   <= w_pcNext;
            // Keep the abandoned request's address on the bus until it is acked.
            if (r_state == FETCH && w_stateNext == DROP) r_oldAddr <= r_pcF;
            if (w_holdLoad) r_holdInstr <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= '0;
            r_pcPlus4D <= '0;
            r_validD   <= 1'b0;
        end else if (FlushD || (!StallD && !w_instrAvail)) begin
            r_instrD <= NOP_INSTR;
            r_validD <= 1'b0;
        end else if (!StallD) begin
            r_instrD   <= w_availInstr;
            r_pcD      <= r_pcF;
            r_pcPlus4D <= r_pcF + c_four;
            r_validD   <= 1'b1;
        end
    end

    assign imem_req  = !rst && (r_state != HOLD);
    assign imem_addr = (r_state == DROP) ? r_oldAddr : r_pcF;
    assign InstrD    = r_instrD;
    assign PCD       = r_pcD;
    assign PCPlus4D  = r_pcPlus4D;
    assign ValidD    = r_validD;
    assign PCF       = r_pcF;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perfFetched, r_perfBubbles, r_perfRedirects;
    logic        w_loadValid, w_loadBubble;

    assign w_loadBubble = FlushD || (!StallD && !w_instrAvail);
    assign w_loadValid  = !FlushD && !StallD && w_instrAvail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perfFetched   <= '0;
            r_perfBubbles   <= '0;
            r_perfRedirects <= '0;
        end else begin
            if (w_loadValid && r_perfFetched != '1) r_perfFetched <= r_perfFetched + 32'd1;
            if (w_loadBubble && r_perfBubbles != '1) r_perfBubbles <= r_perfBubbles + 32'd1;
            if (w_redirect && r_perfRedirects != '1) r_perfRedirects <= r_perfRedirects + 32'd1;
        end
    end

    assign perf_fetched   = r_perfFetched;
    assign perf_bubbles   = r_perfBubbles;
    assign perf_redirects = r_perfRedirects;
`endif

endmodule

`default_nettype wire
